// File: rtl/traffic_light_ctrl.sv
// rtl/traffic_light_ctrl.sv - traffic light sequencer with two timer profiles and blink modes
module traffic_light_ctrl #(
  parameter int unsigned BLINK_HALF = 16
) (
  input  logic        pclk,
  input  logic        preset,
  input  logic        mod_en,
  input  logic        profile,
  input  logic        blink_red,
  input  logic        blink_yellow,
  input  logic [31:0] timer_0,
  input  logic [31:0] timer_1,
  output logic [1:0]  state_o,
  output logic        red_o,
  output logic        yellow_o,
  output logic        green_o,
  output logic        phase_pulse_o
);

  typedef enum logic [1:0] {
    S_RED    = 2'b00,
    S_GREEN  = 2'b01,
    S_YELLOW = 2'b10,
    S_BLINK  = 2'b11
  } state_t;

  localparam logic [15:0] HALF_M1 = 16'(BLINK_HALF - 1);

  state_t      state_q, state_d;
  logic [11:0] cnt_q, cnt_d;
  logic [15:0] bcnt_q, bcnt_d;
  logic        lit_q, lit_d;
  logic        running_q, running_d;
  logic        red_q, red_d;
  logic        yellow_q, yellow_d;
  logic        green_q, green_d;
  logic        pulse_q, pulse_d;

  logic [31:0] sel_timer;
  logic [11:0] g2y, r2g, y2r;
  logic        blink_any;

  assign sel_timer = profile ? timer_1 : timer_0;
  assign g2y       = sel_timer[31:20];
  assign r2g       = sel_timer[19:8];
  assign y2r       = {4'd0, sel_timer[7:0]};
  assign blink_any = blink_red | blink_yellow;

  always_ff @(posedge pclk) begin
    if (preset) begin
      state_q   <= S_RED;
      cnt_q     <= '0;
      bcnt_q    <= '0;
      lit_q     <= 1'b0;
      running_q <= 1'b0;
      red_q     <= 1'b0;
      yellow_q  <= 1'b0;
      green_q   <= 1'b0;
      pulse_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bcnt_q    <= bcnt_d;
      lit_q     <= lit_d;
      running_q <= running_d;
      red_q     <= red_d;
      yellow_q  <= yellow_d;
      green_q   <= green_d;
      pulse_q   <= pulse_d;
    end
  end

  // Priority: disable, then blink request, then (re)entry into RED, then dwell countdown.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bcnt_d    = bcnt_q;
    lit_d     = lit_q;
    running_d = running_q;
    if (!mod_en) begin
      state_d   = S_RED;
      cnt_d     = '0;
      bcnt_d    = '0;
      lit_d     = 1'b0;
      running_d = 1'b0;
    end else if (blink_any) begin
      state_d   = S_BLINK;
      cnt_d     = '0;
      running_d = 1'b1;
      if (state_q != S_BLINK) begin
        bcnt_d = '0;
        lit_d  = 1'b1;
      end else if (bcnt_q == HALF_M1) begin
        bcnt_d = '0;
        lit_d  = ~lit_q;
      end else begin
        bcnt_d = bcnt_q + 16'd1;
      end
    end else if (!running_q || state_q == S_BLINK) begin
      state_d   = S_RED;
      cnt_d     = r2g;
      bcnt_d    = '0;
      lit_d     = 1'b0;
      running_d = 1'b1;
    end else if (cnt_q != 12'd0) begin
      cnt_d = cnt_q - 12'd1;
    end else begin
      case (state_q)
        S_RED:    begin state_d = S_GREEN;  cnt_d = g2y; end
        S_GREEN:  begin state_d = S_YELLOW; cnt_d = y2r; end
        default:  begin state_d = S_RED;    cnt_d = r2g; end
      endcase
    end
  end

  // Lamps are registered, so they are decoded from the next state.
  always_comb begin
    pulse_d  = running_d && (!running_q || state_d != state_q);
    red_d    = running_d && ((state_d == S_RED) ||
                             (state_d == S_BLINK && blink_red && lit_d));
    yellow_d = running_d && ((state_d == S_YELLOW) ||
                             (state_d == S_BLINK && !blink_red && lit_d));
    green_d  = running_d && (state_d == S_GREEN);
  end

  assign state_o       = state_q;
  assign red_o         = red_q;
  assign yellow_o      = yellow_q;
  assign green_o       = green_q;
  assign phase_pulse_o = pulse_q;

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// tb/tb_traffic_light_ctrl.sv - directed self-checking bench for traffic_light_ctrl
module tb_traffic_light_ctrl;

  localparam logic [1:0] SR = 2'b00, SG = 2'b01, SY = 2'b10, SB = 2'b11;

  logic        pclk = 1'b0;
  logic        preset, mod_en, profile, blink_red, blink_yellow;
  logic [31:0] timer_0, timer_1;
  logic [1:0]  state_o;
  logic        red_o, yellow_o, green_o, phase_pulse_o;

  int checks = 0;
  int failures = 0;

  traffic_light_ctrl #(.BLINK_HALF(4)) dut (
    .pclk(pclk), .preset(preset), .mod_en(mod_en), .profile(profile),
    .blink_red(blink_red), .blink_yellow(blink_yellow),
    .timer_0(timer_0), .timer_1(timer_1), .state_o(state_o),
    .red_o(red_o), .yellow_o(yellow_o), .green_o(green_o),
    .phase_pulse_o(phase_pulse_o)
  );

  always #5 pclk = ~pclk;

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  // {red, yellow, green} expected for a running colour state
  function automatic logic [2:0] lamps_of(logic [1:0] s);
    case (s)
      SR:      return 3'b100;
      SG:      return 3'b001;
      SY:      return 3'b010;
      default: return 3'b000;
    endcase
  endfunction

  task automatic test_reset();
    preset = 1'b1; mod_en = 1'b1; blink_red = 1'b1; blink_yellow = 1'b1;
    profile = 1'b0; timer_0 = 32'h0040_0302; timer_1 = 32'h0010_0100;
    tick();
    tick();
    checks++;
    if ({state_o, red_o, yellow_o, green_o, phase_pulse_o} !== 6'b00_000_0) begin
      failures++;
      $display("FAIL reset got=%b exp=%b", {state_o, red_o, yellow_o, green_o, phase_pulse_o}, 6'b00_000_0);
    end
    preset = 1'b0; mod_en = 1'b0; blink_red = 1'b0; blink_yellow = 1'b0;
    tick();
    checks++;
    if ({state_o, red_o, yellow_o, green_o, phase_pulse_o} !== 6'b00_000_0) begin
      failures++;
      $display("FAIL idle got=%b exp=%b", {state_o, red_o, yellow_o, green_o, phase_pulse_o}, 6'b00_000_0);
    end
  endtask

  task automatic test_normal_cycle();
    logic [1:0] es;
    logic       ep;
    int         m;
    timer_0 = 32'h0040_0302; profile = 1'b0;
    mod_en = 1'b1;
    for (int k = 0; k < 24; k++) begin
      tick();
      m  = k % 12;
      es = (m < 4) ? SR : (m < 9) ? SG : SY;
      ep = (m == 0) || (m == 4) || (m == 9);
      checks++;
      if ({state_o, red_o, yellow_o, green_o, phase_pulse_o} !== {es, lamps_of(es), ep}) begin
        failures++;
        $display("FAIL normal cyc=%0d got=%b exp=%b", k,
                 {state_o, red_o, yellow_o, green_o, phase_pulse_o}, {es, lamps_of(es), ep});
      end
    end
  endtask

  task automatic test_profile_switch();
    logic [1:0] exp_seq [0:9] = '{SG, SG, SG, SY, SR, SR, SG, SG, SY, SR};
    logic [1:0] prev;
    logic       ep;
    mod_en = 1'b0; tick();
    mod_en = 1'b1;
    for (int k = 0; k < 6; k++) tick();
    timer_1 = 32'h0010_0100; profile = 1'b1;
    prev = SG;
    for (int k = 0; k < 10; k++) begin
      tick();
      ep = (exp_seq[k] != prev);
      checks++;
      if ({state_o, red_o, yellow_o, green_o, phase_pulse_o} !== {exp_seq[k], lamps_of(exp_seq[k]), ep}) begin
        failures++;
        $display("FAIL profile cyc=%0d got=%b exp=%b", k,
                 {state_o, red_o, yellow_o, green_o, phase_pulse_o}, {exp_seq[k], lamps_of(exp_seq[k]), ep});
      end
      prev = exp_seq[k];
    end
    profile = 1'b0;
  endtask

  task automatic test_zero_fields();
    logic [1:0] es;
    timer_0 = 32'h0; profile = 1'b0;
    mod_en = 1'b0; tick();
    mod_en = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
      es = (k % 3 == 0) ? SR : (k % 3 == 1) ? SG : SY;
      checks++;
      if ({state_o, red_o, yellow_o, green_o, phase_pulse_o} !== {es, lamps_of(es), 1'b1}) begin
        failures++;
        $display("FAIL zero cyc=%0d got=%b exp=%b", k,
                 {state_o, red_o, yellow_o, green_o, phase_pulse_o}, {es, lamps_of(es), 1'b1});
      end
    end
  endtask

  task automatic test_blink();
    logic       lit;
    logic [2:0] el;
    logic [1:0] es;
    timer_0 = 32'h0040_0302; profile = 1'b0;
    mod_en = 1'b0; tick();
    mod_en = 1'b1; tick(); tick();
    blink_yellow = 1'b1;
    for (int k = 0; k < 18; k++) begin
      if (k == 10) blink_red = 1'b1;
      tick();
      lit = ((k / 4) % 2 == 0);
      el  = (k >= 10) ? {lit, 2'b00} : {1'b0, lit, 1'b0};
      checks++;
      if ({state_o, red_o, yellow_o, green_o, phase_pulse_o} !== {SB, el, k == 0}) begin
        failures++;
        $display("FAIL blink cyc=%0d got=%b exp=%b", k,
                 {state_o, red_o, yellow_o, green_o, phase_pulse_o}, {SB, el, k == 0});
      end
    end
    blink_red = 1'b0; blink_yellow = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      es = (k < 4) ? SR : SG;
      checks++;
      if ({state_o, red_o, yellow_o, green_o, phase_pulse_o} !== {es, lamps_of(es), k == 0 || k == 4}) begin
        failures++;
        $display("FAIL blink_exit cyc=%0d got=%b exp=%b", k,
                 {state_o, red_o, yellow_o, green_o, phase_pulse_o}, {es, lamps_of(es), k == 0 || k == 4});
      end
    end
  endtask

  task automatic test_disable_precedence();
    mod_en = 1'b0; blink_red = 1'b1;
    for (int k = 0; k < 2; k++) begin
      tick();
      checks++;
      if ({state_o, red_o, yellow_o, green_o, phase_pulse_o} !== 6'b00_000_0) begin
        failures++;
        $display("FAIL disable cyc=%0d got=%b exp=%b", k,
                 {state_o, red_o, yellow_o, green_o, phase_pulse_o}, 6'b00_000_0);
      end
    end
    blink_red = 1'b0;
  endtask

  task automatic test_reset_mid_green();
    logic [1:0] es;
    timer_0 = 32'h0040_0302; profile = 1'b0;
    mod_en = 1'b1;
    for (int k = 0; k < 6; k++) tick();
    checks++;
    if (state_o !== SG) begin
      failures++;
      $display("FAIL pre_reset_state got=%b exp=%b", state_o, SG);
    end
    preset = 1'b1; tick();
    checks++;
    if ({state_o, red_o, yellow_o, green_o, phase_pulse_o} !== 6'b00_000_0) begin
      failures++;
      $display("FAIL mid_reset got=%b exp=%b", {state_o, red_o, yellow_o, green_o, phase_pulse_o}, 6'b00_000_0);
    end
    preset = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      es = (k < 4) ? SR : SG;
      checks++;
      if ({state_o, red_o, yellow_o, green_o, phase_pulse_o} !== {es, lamps_of(es), k == 0 || k == 4}) begin
        failures++;
        $display("FAIL post_reset cyc=%0d got=%b exp=%b", k,
                 {state_o, red_o, yellow_o, green_o, phase_pulse_o}, {es, lamps_of(es), k == 0 || k == 4});
      end
    end
  endtask

  initial begin
    preset = 1'b1; mod_en = 1'b0; profile = 1'b0;
    blink_red = 1'b0; blink_yellow = 1'b0;
    timer_0 = '0; timer_1 = '0;
    test_reset();
    test_normal_cycle();
    test_profile_switch();
    test_zero_fields();
    test_blink();
    test_disable_precedence();
    test_reset_mid_green();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
